traffic_phase_sequencer: RTL

Parametrised traffic-light phase sequencer for an N-road junction with an integrated phase timer and programmable phase durations. It steps each road through RED1 -> YEL1 -> GREEN -> YEL2 -> RED2, with optional demand-driven road skipping and emergency preemption. It replaces the fixed 4-road control unit plus external counter and drives the per-road light register directly.

---
 rtl/traffic_pkg.sv | 30 +++
 rtl/phase_timer.sv | 36 +++
 rtl/traffic_phase_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared light codes, state codes and the per-phase light decode for the
// traffic phase sequencer.
package traffic_pkg;

    typedef enum logic [1:0] {
        LIGHT_RED    = 2'b00,
        LIGHT_YELLOW = 2'b01,
        LIGHT_GREEN  = 2'b10
    } light_e;

    typedef enum logic [2:0] {
        S_RED1  = 3'b000,
        S_YEL1  = 3'b001,
        S_GREEN = 3'b010,
        S_YEL2  = 3'b011,
        S_RED2  = 3'b100,
        S_HOLD  = 3'b101,
        S_IDLE  = 3'b111
    } state_e;

    // Light shown by the active road; every other road stays red.
    function automatic light_e active_light(input state_e s);
        case (s)
            S_YEL1, S_YEL2: return LIGHT_YELLOW;
            S_GREEN:        return LIGHT_GREEN;
            default:        return LIGHT_RED;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Down-counting phase timer: loads d-1 (d=0 treated as 1), counts to zero,
// holds its value while frozen.
module phase_timer #(
    parameter int DUR_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [DUR_W-1:0] value,
    input  logic             freeze,
    output logic             zero
);

    logic [DUR_W-1:0] timer_d, timer_q;

    // NOTE: every variable written here gets its default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        timer_d = timer_q;
        if (load) begin
            timer_d = (value == '0) ? '0 : value - DUR_W'(1);
        end else if (!freeze && timer_q != '0) begin
            timer_d = timer_q - DUR_W'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers update
    // together on the edge regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) timer_q <= '0;
        else       timer_q <= timer_d;
    end

    assign zero = (timer_q == '0);

endmodule

// File: rtl/traffic_phase_sequencer.sv
// N-road traffic phase sequencer: RED1 -> YEL1 -> GREEN -> YEL2 -> RED2 per
// road, with optional demand-driven road skipping and emergency preemption.
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int  ROADS     = 4,
    parameter int  DUR_W     = 4,
    parameter bit  DEMAND_EN = 1'b0,
    localparam int RW        = $clog2(ROADS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [DUR_W-1:0]   t_red,
    input  logic [DUR_W-1:0]   t_yellow,
    input  logic [DUR_W-1:0]   t_green,
    input  logic [ROADS-1:0]   demand,
    input  logic               emerg,
    input  logic [RW-1:0]      emerg_road,
    output logic [RW-1:0]      road,
    output logic [2:0]         phase,
    output logic [2*ROADS-1:0] lights,
    output logic               phase_valid,
    output logic               busy
);

    state_e           state_d, state_q;
    logic [RW-1:0]    road_d, road_q, road_inc;
    logic [ROADS-1:0] req_d, req_q, pending, demand_eff, clr_mask;
    logic             phase_valid_d, phase_valid_q;
    logic             emerg_ok, em_other, em_same, expire, freeze;
    logic [DUR_W-1:0] dur_sel;
    logic [RW:0]      pick_first, pick_after;

    // Returns {found, index} of the first pending road, scanning from base
    // upward with wrap; the lowest offset from base wins.
    function automatic logic [RW:0] rr_pick(input logic [ROADS-1:0] pend,
                                            input logic [RW-1:0]    base);
        logic [RW:0] r;
        int          idx;
        r = '0;
        for (int k = ROADS - 1; k >= 0; k--) begin
            idx = (int'(base) + k) % ROADS;
            if (pend[idx]) r = {1'b1, RW'(idx)};
        end
        return r;
    endfunction

    assign demand_eff = DEMAND_EN ? demand : '0;
    assign pending    = req_q | demand_eff;
    assign road_inc   = (int'(road_q) == ROADS - 1) ? '0 : road_q + RW'(1);
    assign pick_first = rr_pick(pending, '0);
    assign pick_after = rr_pick(pending, road_inc);

    assign emerg_ok = emerg && (int'(emerg_road) < ROADS);
    assign em_other = emerg_ok && (emerg_road != road_q);
    assign em_same  = emerg_ok && (emerg_road == road_q);
    // The active road's own emergency keeps its green alive indefinitely.
    assign freeze   = (state_q == S_GREEN) && em_same;

    always_comb begin
        state_d = state_q;
        road_d  = road_q;
        case (state_q)
            S_IDLE, S_HOLD: begin
                if (emerg_ok) begin
                    state_d = S_RED1;
                    road_d  = emerg_road;
                end else if (state_q == S_IDLE && start) begin
                    if (!DEMAND_EN) begin
                        state_d = S_RED1;
                        road_d  = '0;
                    end else if (pick_first[RW]) begin
                        state_d = S_RED1;
                        road_d  = pick_first[RW-1:0];
                    end else begin
                        state_d = S_HOLD;
                    end
                end else if (state_q == S_HOLD && pick_after[RW]) begin
                    state_d = S_RED1;
                    road_d  = pick_after[RW-1:0];
                end
            end
            S_RED1: begin
                if (em_other)    state_d = S_RED2;
                else if (expire) state_d = S_YEL1;
            end
            S_YEL1: begin
                if (em_other)    state_d = S_RED2;
                else if (expire) state_d = S_GREEN;
            end
            S_GREEN: begin
                if (em_other)                state_d = S_YEL2;
                else if (!em_same && expire) state_d = S_YEL2;
            end
            S_YEL2: begin
                if (expire) state_d = S_RED2;
            end
            S_RED2: begin
                if (expire) begin
                    if (em_other) begin
                        state_d = S_RED1;
                        road_d  = emerg_road;
                    end else if (!DEMAND_EN) begin
                        state_d = S_RED1;
                        road_d  = road_inc;
                    end else if (pick_after[RW]) begin
                        state_d = S_RED1;
                        road_d  = pick_after[RW-1:0];
                    end else begin
                        state_d = S_HOLD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign phase_valid_d = (state_d != state_q) && (state_d != S_IDLE) && (state_d != S_HOLD);

    always_comb begin
        case (state_d)
            S_YEL1, S_YEL2: dur_sel = t_yellow;
            S_GREEN:        dur_sel = t_green;
            default:        dur_sel = t_red;
        endcase
    end

    // A set and a clear of the same request bit in one cycle leaves it set.
    always_comb begin
        clr_mask = '0;
        if (state_d == S_GREEN && state_q != S_GREEN) clr_mask[road_q] = 1'b1;
        req_d = (req_q & ~clr_mask) | demand_eff;
    end

    phase_timer #(.DUR_W(DUR_W)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (phase_valid_d),
        .value  (dur_sel),
        .freeze (freeze),
        .zero   (expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            road_q        <= '0;
            req_q         <= '0;
            phase_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            road_q        <= road_d;
            req_q         <= req_d;
            phase_valid_q <= phase_valid_d;
        end
    end

    always_comb begin
        lights = '0;
        if (busy) lights[2*int'(road_q) +: 2] = active_light(state_q);
    end

    assign road        = road_q;
    assign phase       = state_q;
    assign phase_valid = phase_valid_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_HOLD);

endmodule
